// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants for the 8-bit ALU: the data width and the opcode encodings.
`timescale 1ns/1ps
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
// Combinational 8-bit adder/subtractor with carry and nibble-carry outputs.
//   a, b   : operands
//   sub    : 0 = a + b, 1 = a - b
//   sum    : low 8 bits of the result
//   cout   : carry out of bit 7 (add) or borrow, 1 when a < b (sub)
//   acout  : carry/borrow from bit 3 into bit 4
`timescale 1ns/1ps
module alu_addsub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              acout
);

  logic [DATA_W:0] w_full;

  // 9-bit zero-extended arithmetic: bit 8 is the carry, or the borrow on subtract.
  assign w_full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});

  assign sum  = w_full[DATA_W-1:0];
  assign cout = w_full[DATA_W];

  // The carry (or borrow) entering bit 4 is recovered from the bit-4 sum:
  // s4 = a4 ^ b4 ^ in4 holds for both add and subtract.
  assign acout = a[4] ^ b[4] ^ w_full[4];

endmodule

// File: rtl/alu.sv
// alu
// Registered 8-bit ALU with 8085-style flags. Result and flags are computed
// combinationally from the current inputs and loaded on every rising clk edge.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears all outputs
//   Opcode  : operation select (see alu_pkg)
//   Op1     : operand A
//   Op2     : operand B (ignored by NOT and the shifts)
//   Res     : registered result
//   C, AC   : registered carry/borrow and nibble carry/borrow
//   Z, S    : registered zero and sign of Res
`timescale 1ns/1ps
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        Opcode,
  input  logic [DATA_W-1:0] Op1,
  input  logic [DATA_W-1:0] Op2,
  output logic [DATA_W-1:0] Res,
  output logic              C,
  output logic              AC,
  output logic              Z,
  output logic              S
);

  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_acout;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_ac;

  logic [DATA_W-1:0] r_res;
  logic              r_c;
  logic              r_ac;
  logic              r_z;
  logic              r_s;

  alu_addsub u_addsub (
    .a     (Op1),
    .b     (Op2),
    .sub   (Opcode == OP_SUB),
    .sum   (w_sum),
    .cout  (w_cout),
    .acout (w_acout)
  );

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_ac  = 1'b0;
    case (Opcode)
      OP_ADD, OP_SUB: begin
        w_res = w_sum;
        w_c   = w_cout;
        w_ac  = w_acout;
      end
      OP_AND: w_res = Op1 & Op2;
      OP_OR:  w_res = Op1 | Op2;
      OP_XOR: w_res = Op1 ^ Op2;
      OP_NOT: w_res = ~Op1;
      OP_SHL: begin
        w_res = {Op1[DATA_W-2:0], 1'b0};
        w_c   = Op1[DATA_W-1];
      end
      OP_SHR: begin
        w_res = {1'b0, Op1[DATA_W-1:1]};
        w_c   = Op1[0];
      end
      default: begin
        w_res = '0;
        w_c   = 1'b0;
      end
    endcase
  end

  // Z resets to 0 even though a zero result would normally set it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_c   <= 1'b0;
      r_ac  <= 1'b0;
      r_z   <= 1'b0;
      r_s   <= 1'b0;
    end else begin
      r_res <= w_res;
      r_c   <= w_c;
      r_ac  <= w_ac;
      r_z   <= (w_res == '0);
      r_s   <= w_res[DATA_W-1];
    end
  end

  assign Res = r_res;
  assign C   = r_c;
  assign AC  = r_ac;
  assign Z   = r_z;
  assign S   = r_s;

endmodule

// File: tb/tb_alu.sv
`timescale 1ns/1ps
module tb_alu;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [2:0] Opcode;
  logic [7:0] Op1;
  logic [7:0] Op2;
  logic [7:0] Res;
  logic       C;
  logic       AC;
  logic       Z;
  logic       S;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       ac;
    logic       z;
    logic       s;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Opcode (Opcode),
    .Op1    (Op1),
    .Op2    (Op2),
    .Res    (Res),
    .C      (C),
    .AC     (AC),
    .Z      (Z),
    .S      (S)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] res, input logic c,
                       input logic ac, input logic z, input logic s);
    checks++;
    if ({Res, C, AC, Z, S} !== {res, c, ac, z, s}) begin
      errors++;
      $display("FAIL %s: got Res=%02h C=%b AC=%b Z=%b S=%b, expected Res=%02h C=%b AC=%b Z=%b S=%b",
               name, Res, C, AC, Z, S, res, c, ac, z, s);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    Opcode = op;
    Op1    = a;
    Op2    = b;
  endtask

  initial begin
    //                name          op    a      b      res    c  ac z  s
    vecs.push_back('{"add_0f_01",  3'd0, 8'h0F, 8'h01, 8'h10, 0, 1, 0, 0});
    vecs.push_back('{"add_f8_08",  3'd0, 8'hF8, 8'h08, 8'h00, 1, 1, 1, 0});
    vecs.push_back('{"add_ff_01",  3'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 1, 0});
    vecs.push_back('{"add_80_80",  3'd0, 8'h80, 8'h80, 8'h00, 1, 0, 1, 0});
    vecs.push_back('{"sub_05_07",  3'd1, 8'h05, 8'h07, 8'hFE, 1, 1, 0, 1});
    vecs.push_back('{"sub_42_42",  3'd1, 8'h42, 8'h42, 8'h00, 0, 0, 1, 0});
    vecs.push_back('{"sub_00_01",  3'd1, 8'h00, 8'h01, 8'hFF, 1, 1, 0, 1});
    vecs.push_back('{"sub_10_01",  3'd1, 8'h10, 8'h01, 8'h0F, 0, 1, 0, 0});
    vecs.push_back('{"and_f0_3c",  3'd2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0});
    vecs.push_back('{"or_f0_3c",   3'd3, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 1});
    vecs.push_back('{"xor_f0_3c",  3'd4, 8'hF0, 8'h3C, 8'hCC, 0, 0, 0, 1});
    vecs.push_back('{"not_f0",     3'd5, 8'hF0, 8'h3C, 8'h0F, 0, 0, 0, 0});
    vecs.push_back('{"not_00",     3'd5, 8'h00, 8'hFF, 8'hFF, 0, 0, 0, 1});
    vecs.push_back('{"shl_81",     3'd6, 8'h81, 8'h00, 8'h02, 1, 0, 0, 0});
    vecs.push_back('{"shl_7f",     3'd6, 8'h7F, 8'hFF, 8'hFE, 0, 0, 0, 1});
    vecs.push_back('{"shr_81",     3'd7, 8'h81, 8'h00, 8'h40, 1, 0, 0, 0});
    vecs.push_back('{"shr_01",     3'd7, 8'h01, 8'h00, 8'h00, 1, 0, 1, 0});

    clk    = 1'b0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    drive(3'd2, 8'hF8, 8'h00);

    // Asynchronous reset with no clock running.
    #2 rst_n = 1'b0;
    #1 check("reset_async", 8'h00, 0, 0, 0, 0);
    #5 check("reset_hold", 8'h00, 0, 0, 0, 0);
    rst_n  = 1'b1;
    #1 check("reset_release_no_edge", 8'h00, 0, 0, 0, 0);
    clk_en = 1'b1;
    @(posedge clk); #1;
    check("first_edge_and", 8'h00, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].res, vecs[i].c, vecs[i].ac, vecs[i].z, vecs[i].s);
    end

    // Outputs hold between edges when inputs change.
    @(negedge clk);
    drive(3'd0, 8'h01, 8'h01);
    #2 check("hold_between_edges", 8'h00, 1, 0, 1, 0);

    // Back-to-back opcodes with A=96, B=3B.
    @(negedge clk); drive(3'd0, 8'h96, 8'h3B);
    @(posedge clk); #1 check("pipe_add", 8'hD1, 0, 1, 0, 1);
    @(negedge clk); drive(3'd1, 8'h96, 8'h3B);
    @(posedge clk); #1 check("pipe_sub", 8'h5B, 0, 1, 0, 0);
    @(negedge clk); drive(3'd2, 8'h96, 8'h3B);
    @(posedge clk); #1 check("pipe_and", 8'h12, 0, 0, 0, 0);
    @(negedge clk); drive(3'd3, 8'h96, 8'h3B);
    @(posedge clk); #1 check("pipe_or", 8'hBF, 0, 0, 0, 1);

    // Reset mid-sequence: clears at once, stays clear across an edge.
    @(negedge clk); drive(3'd4, 8'h96, 8'h3B);
    #2 rst_n = 1'b0;
    #1 check("pipe_reset_async", 8'h00, 0, 0, 0, 0);
    @(posedge clk); #1 check("pipe_reset_edge", 8'h00, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    drive(3'd4, 8'h96, 8'h3B);
    @(posedge clk); #1 check("pipe_xor", 8'hAD, 0, 0, 0, 1);
    @(negedge clk); drive(3'd5, 8'h96, 8'h3B);
    @(posedge clk); #1 check("pipe_not", 8'h69, 0, 0, 0, 0);
    @(negedge clk); drive(3'd6, 8'h96, 8'h3B);
    @(posedge clk); #1 check("pipe_shl", 8'h2C, 1, 0, 0, 0);
    @(negedge clk); drive(3'd7, 8'h96, 8'h3B);
    @(posedge clk); #1 check("pipe_shr", 8'h4B, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
